// File: rtl/wait_state_mem.sv
// Word-addressed memory with a req/ready handshake and WAIT configurable wait states.
// Optional byte-lane write enables are compiled in when MEM_BYTE_WRITE_EN is defined.
module wait_state_mem #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned WAIT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] a_i,
  input  logic [DATA_W-1:0] wd_i,
`ifdef MEM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0] be_i,
`endif
  output logic [DATA_W-1:0] rd_o,
  output logic              ready_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT > 0) ? (WAIT - 1) : 0);
  localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  logic [DATA_W-1:0]  rd_q;
  logic               err_q;
  logic               commit;
  logic               in_range;
  logic               wr_en;
  logic [MEM_AW-1:0]  mem_addr;
  logic [DATA_W-1:0]  wr_word;

  logic [DATA_W-1:0] mem [DEPTH];

  // The *_d operands equal the live inputs on an accept edge and the captured
  // copies otherwise, so they are exactly what the commit edge must use.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (req_i) begin
          we_d  = we_i;
          idx_d = a_i[ADDR_W-1:2];
          wd_d  = wd_i;
          if (WAIT == 0) begin
            state_d = S_RESP;
            commit  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_range = ({1'b0, idx_d} < DEPTH_C);
  assign mem_addr = idx_d[MEM_AW-1:0];
  assign wr_en    = commit & we_d & in_range & rst_ni;

`ifdef MEM_BYTE_WRITE_EN
  logic [NB-1:0]     be_q, be_d;
  logic [DATA_W-1:0] old_word;

  always_comb begin
    be_d = be_q;
    if ((state_q == S_IDLE || state_q == S_RESP) && req_i) begin
      be_d = be_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      be_q <= '0;
    end else begin
      be_q <= be_d;
    end
  end

  // Lanes without an enable keep the stored byte; the merged word is also the echo.
  assign old_word = mem[mem_addr];
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign wr_word[8*gi +: 8] = be_d[gi] ? wd_d[8*gi +: 8] : old_word[8*gi +: 8];
  end
`else
  assign wr_word = wd_d;
`endif

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[mem_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      if (commit) begin
        err_q <= ~in_range;
        if (!in_range) begin
          rd_q <= '0;
        end else if (we_d) begin
          rd_q <= wr_word;
        end else begin
          rd_q <= mem[mem_addr];
        end
      end
    end
  end

  assign rd_o    = rd_q;
  assign err_o   = err_q;
  assign ready_o = (state_q == S_RESP);
  assign busy_o  = (state_q != S_IDLE);

endmodule
